// File: rtl/tri_array_clkseq.sv
// Clock-start/stop and scan-gate sequencer for array LCB control.
// All outputs are registered and decoded from the next state.
module tri_array_clkseq #(
  parameter int unsigned START_DLY = 4,
  parameter int unsigned STOP_DLY  = 4,
  parameter int unsigned SG_SETUP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       scan_req,
  input  logic [7:0] scan_len,
  input  logic       err_clr,
  output logic       thold,
  output logic       sg,
  output logic       scan_diag_dc,
  output logic       scan_en,
  output logic       running,
  output logic       busy,
  output logic       ack,
  output logic       err
);

  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_STARTING,
    ST_RUNNING,
    ST_STOPPING,
    ST_SG_PRE,
    ST_SCANNING,
    ST_SG_POST
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt_cnt;
  logic [CW-1:0] len_q;
  logic [CW-1:0] nxt_len;
  logic          nxt_ack;
  logic          err_set;
  logic          last;
  logic          any_req;

  assign last    = (cnt == CW'(1));
  assign any_req = start_req | stop_req | scan_req;

  // Next-state, counter load and error detection
  always_comb begin
    nxt_state = state;
    nxt_cnt   = (cnt != '0) ? cnt - CW'(1) : '0;
    nxt_len   = len_q;
    nxt_ack   = 1'b0;
    err_set   = 1'b0;
    case (state)
      ST_STOPPED: begin
        err_set = stop_req;
        if (scan_req) begin
          nxt_state = ST_SG_PRE;
          nxt_cnt   = CW'(SG_SETUP);
          nxt_len   = scan_len;
        end else if (start_req) begin
          nxt_state = ST_STARTING;
          nxt_cnt   = CW'(START_DLY);
        end
      end
      ST_STARTING: begin
        err_set = any_req;
        if (last) begin
          nxt_state = ST_RUNNING;
          nxt_ack   = 1'b1;
        end
      end
      ST_RUNNING: begin
        err_set = start_req | scan_req;
        if (stop_req) begin
          nxt_state = ST_STOPPING;
          nxt_cnt   = CW'(STOP_DLY);
        end
      end
      ST_STOPPING: begin
        err_set = any_req;
        if (last) begin
          nxt_state = ST_STOPPED;
          nxt_ack   = 1'b1;
        end
      end
      ST_SG_PRE: begin
        err_set = any_req;
        if (last) begin
          // A zero-length scan skips the shift window entirely
          if (len_q == '0) begin
            nxt_state = ST_SG_POST;
            nxt_cnt   = CW'(SG_SETUP);
          end else begin
            nxt_state = ST_SCANNING;
            nxt_cnt   = len_q;
          end
        end
      end
      ST_SCANNING: begin
        err_set = any_req;
        if (last) begin
          nxt_state = ST_SG_POST;
          nxt_cnt   = CW'(SG_SETUP);
        end
      end
      ST_SG_POST: begin
        err_set = any_req;
        if (last) begin
          nxt_state = ST_STOPPED;
          nxt_ack   = 1'b1;
        end
      end
      default: begin
        nxt_state = ST_STOPPED;
        nxt_cnt   = '0;
      end
    endcase
  end

  // State, counter and registered output decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_STOPPED;
      cnt          <= '0;
      len_q        <= '0;
      thold        <= 1'b1;
      sg           <= 1'b0;
      scan_diag_dc <= 1'b0;
      scan_en      <= 1'b0;
      running      <= 1'b0;
      busy         <= 1'b0;
      ack          <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      len_q        <= nxt_len;
      thold        <= (nxt_state != ST_RUNNING);
      sg           <= (nxt_state == ST_SG_PRE) || (nxt_state == ST_SCANNING) ||
                      (nxt_state == ST_SG_POST);
      scan_diag_dc <= (nxt_state == ST_SG_PRE) || (nxt_state == ST_SCANNING) ||
                      (nxt_state == ST_SG_POST);
      scan_en      <= (nxt_state == ST_SCANNING);
      running      <= (nxt_state == ST_RUNNING);
      busy         <= (nxt_state != ST_STOPPED) && (nxt_state != ST_RUNNING);
      ack          <= nxt_ack;
      err          <= err_set | (err & ~err_clr);
    end
  end

endmodule

// File: doc/tri_array_clkseq.md
TRI_ARRAY_CLKSEQ -- requirements
Module: tri_array_clkseq

Interface
REQ-001 Parameter START_DLY, 4: cycles thold held high in STARTING (legal 1..255).
REQ-002 Parameter STOP_DLY, 4: cycles thold held high in STOPPING before STOPPED (legal 1..255).
REQ-003 Parameter SG_SETUP, 2: sg setup and hold cycles around the scan window (legal 1..255).
REQ-004 clk  in  1  single clock; every flop is rising-edge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start_req  in  1  level; request clocks running.
REQ-007 stop_req  in  1  level; request clocks stopped.
REQ-008 scan_req  in  1  level; request a scan window.
REQ-009 scan_len  in  8  shift count, sampled when scan_req is accepted.
REQ-010 err_clr  in  1  clears the err output.
REQ-011 thold  out  1  hold to array LCB control; 1 = clocks held.
REQ-012 sg  out  1  scan gate to array LCB control.
REQ-013 scan_diag_dc  out  1  high for the whole scan sequence (SG_PRE, SCANNING, SG_POST).
REQ-014 scan_en  out  1  shift enable; high only in SCANNING.
REQ-015 running  out  1  high only in RUNNING.
REQ-016 busy  out  1  high in STARTING, STOPPING, SG_PRE, SCANNING, SG_POST.
REQ-017 ack  out  1  one-cycle pulse when a requested sequence completes.
REQ-018 err  out  1  sticky illegal-request flag.

Function
REQ-019 States SHALL be STOPPED, STARTING, RUNNING, STOPPING, SG_PRE, SCANNING, SG_POST; every output SHALL be registered.
REQ-020 Outputs SHALL decode from state: thold=0 only in RUNNING, else 1; sg=1 in SG_PRE, SCANNING, SG_POST.
REQ-021 STOPPED with start_req=1 and scan_req=0: SHALL go to STARTING next cycle and load the 8-bit down-counter with START_DLY.
REQ-022 STARTING: SHALL stay exactly START_DLY cycles, then go to RUNNING with ack=1 on the first RUNNING cycle.
REQ-023 Start latency: start_req sampled in cycle N SHALL give thold=0 first in cycle N+1+START_DLY.
REQ-024 RUNNING with stop_req=1: SHALL go to STOPPING for exactly STOP_DLY cycles, then STOPPED with ack=1 on the first STOPPED cycle.
REQ-025 STOPPED with scan_req=1: SHALL capture scan_len and go to SG_PRE for SG_SETUP cycles.
REQ-026 After SG_PRE the block SHALL go to SCANNING for exactly the captured scan_len cycles (scan_en high those cycles).
REQ-027 After SCANNING the block SHALL go to SG_POST for SG_SETUP cycles, then STOPPED with ack=1.
REQ-028 Captured scan_len=0: SG_PRE SHALL go directly to SG_POST, and scan_en SHALL never assert.
REQ-029 STOPPED with start_req and scan_req both high: scan SHALL win; start_req SHALL be ignored and is not an error.
REQ-030 RUNNING with start_req and stop_req both high: stop SHALL win; start_req SHALL be ignored.
REQ-031 Requests arriving while busy=1 SHALL be ignored and SHALL NOT alter the sequence or the captured scan_len.
REQ-032 err SHALL set on any of these cycles:
- start_req or scan_req high in RUNNING;
- stop_req high in STOPPED;
- any request high while busy=1.
REQ-033 err SHALL hold until err_clr=1; if err_clr and a new error occur in the same cycle, err SHALL remain 1.
REQ-034 Request inputs are levels: a request still high after its sequence completes SHALL be evaluated again from the new state, including the ack cycle.
REQ-035 The counter SHALL never wrap: it loads on state entry and decrements to 0; the state transitions on the cycle the count is 1.

Reset
REQ-036 With rst=1 at a rising edge, next state SHALL be STOPPED with the following values, independent of any other input:
- thold=1;
- sg=0, scan_diag_dc=0, scan_en=0;
- running=0, busy=0, ack=0, err=0;
- counter=0, captured scan_len=0.
REQ-037 rst mid-sequence (any state) SHALL abort immediately to the REQ-036 values, with no ack pulse.

Verification
REQ-038 Reset, then start_req pulse in cycle 5 -> busy=1 in cycles 6-9; thold=0, running=1 and ack=1 in cycle 10.
REQ-039 From RUNNING, stop_req in cycle N -> thold=1 from N+1; STOPPED with ack=1 in cycle N+5; err=0 throughout.
REQ-040 scan_req with scan_len=3 -> timing as follows:
- sg=1 for 2+3+2=7 cycles;
- scan_en=1 for exactly the middle 3 cycles;
- scan_diag_dc matches sg;
- ack=1 after sg drops.
REQ-041 scan_req with scan_len=0 -> sg=1 for 4 cycles, scan_en never 1; start_req+scan_req together in STOPPED -> scan sequence runs.
REQ-042 stop_req in STOPPED -> err=1 and no state change; err_clr -> err=0 next cycle; start_req during STARTING -> err=1 and timing unchanged.
REQ-043 rst asserted during SCANNING -> next cycle thold=1, sg=0, scan_en=0, busy=0, ack=0.
